// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples SCLK/CS/MOSI in the system clock domain,
// receives and transmits LSB-first frames, and strobes each received byte out.
module spi_slave #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  SCLK,
   input  logic                  CS,
   input  logic                  MOSI,
   output logic                  MISO,
   input  logic [DATA_WIDTH-1:0] txData,
   input  logic                  txLoad,
   output logic [DATA_WIDTH-1:0] rxData,
   output logic                  rxValid,
   output logic                  busy,
   output logic                  txPending
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic [SYNC_STAGES-1:0] sclk_sync_reg;
   logic [SYNC_STAGES-1:0] cs_sync_reg;
   logic [SYNC_STAGES-1:0] mosi_sync_reg;
   logic                   sclk_d_reg;
   logic                   cs_d_reg;

   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sclk_rise;
   logic                   sclk_fall;
   logic                   cs_rise;
   logic                   cs_fall;

   logic [DATA_WIDTH-1:0]  hold_reg;
   logic                   pend_reg;
   logic [DATA_WIDTH-1:0]  tx_shift_reg;
   logic [DATA_WIDTH-1:0]  rx_shift_reg;
   logic [CNT_W-1:0]       bit_cnt_reg;
   logic                   miso_bit_reg;
   logic                   miso_reg;
   logic [DATA_WIDTH-1:0]  rx_data_reg;
   logic                   rx_valid_reg;

   logic                   start;
   logic                   last_bit;
   logic                   capture;
   logic                   to_idle;
   logic                   shift_rise;
   logic                   shift_fall;

   // CS synchronizer resets high so a deasserted select is seen as idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_sync_reg <= '0;
         cs_sync_reg   <= '1;
         mosi_sync_reg <= '0;
         sclk_d_reg    <= 1'b0;
         cs_d_reg      <= 1'b1;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SCLK};
         cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], CS};
         mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
         sclk_d_reg    <= sclk_s;
         cs_d_reg      <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
   assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d_reg;
   assign sclk_fall = ~sclk_s & sclk_d_reg;
   assign cs_rise   = cs_s & ~cs_d_reg;
   assign cs_fall   = ~cs_s & cs_d_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      last_bit   = 1'b0;
      capture    = 1'b0;
      to_idle    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (cs_fall) begin
               start      = 1'b1;
               state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               to_idle    = 1'b1;
               state_next = ST_IDLE;
            end else if (sclk_fall && (bit_cnt_reg == LAST_BIT)) begin
               last_bit   = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            capture = 1'b1;
            if (cs_s) begin
               to_idle    = 1'b1;
               state_next = ST_IDLE;
            end else begin
               state_next = ST_SHIFT;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign shift_rise = (state_reg == ST_SHIFT) && sclk_rise && !cs_rise;
   assign shift_fall = (state_reg == ST_SHIFT) && sclk_fall && !cs_rise;

   // A load coinciding with a consume keeps the new byte pending.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_reg <= '0;
         pend_reg <= 1'b0;
      end else begin
         if (txLoad) begin
            hold_reg <= txData;
            pend_reg <= 1'b1;
         end else if (start || last_bit) begin
            pend_reg <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_shift_reg <= DEFAULT_TX;
         rx_shift_reg <= '0;
         bit_cnt_reg  <= '0;
         miso_bit_reg <= 1'b0;
         miso_reg     <= 1'b0;
         rx_data_reg  <= '0;
         rx_valid_reg <= 1'b0;
      end else begin
         if (start || last_bit) begin
            tx_shift_reg <= pend_reg ? hold_reg : DEFAULT_TX;
         end else if (shift_rise) begin
            miso_bit_reg <= tx_shift_reg[0];
            tx_shift_reg <= tx_shift_reg >> 1;
         end

         if (start) begin
            bit_cnt_reg  <= '0;
            rx_shift_reg <= '0;
         end else if (shift_fall) begin
            rx_shift_reg <= {mosi_s, rx_shift_reg[DATA_WIDTH-1:1]};
            bit_cnt_reg  <= last_bit ? '0 : bit_cnt_reg + CNT_W'(1);
         end

         // Leaving the frame drops any partial byte and parks MISO low.
         if (to_idle) begin
            bit_cnt_reg  <= '0;
            rx_shift_reg <= '0;
            miso_bit_reg <= 1'b0;
         end

         rx_valid_reg <= capture;
         if (capture) begin
            rx_data_reg <= rx_shift_reg;
         end

         miso_reg <= miso_bit_reg;
      end
   end

   assign MISO      = miso_reg;
   assign rxData    = rx_data_reg;
   assign rxValid   = rx_valid_reg;
   assign busy      = (state_reg != ST_IDLE);
   assign txPending = pend_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: drives it as an SPI master, predicts bytes from a
// holding-register model, and scores rxValid strobes from a separate monitor.
module tb_spi_slave;

   localparam int         H   = 6;
   localparam logic [7:0] DEF = 8'h00;

   logic       clk     = 1'b0;
   logic       reset   = 1'b0;
   logic       SCLK    = 1'b0;
   logic       CS      = 1'b1;
   logic       MOSI    = 1'b0;
   logic       txLoad  = 1'b0;
   logic [7:0] txData  = 8'h00;
   logic       MISO;
   logic [7:0] rxData;
   logic       rxValid;
   logic       busy;
   logic       txPending;

   int checks = 0;
   int errors = 0;

   logic [7:0] rx_exp[$];
   logic [7:0] mosi_q[$];
   logic [7:0] model_hold    = 8'h00;
   logic       model_pend    = 1'b0;
   logic [7:0] model_last_rx = 8'h00;
   logic [7:0] miso_acc      = 8'h00;
   logic [7:0] mon_exp;

   spi_slave #(
      .DATA_WIDTH (8),
      .SYNC_STAGES(2),
      .DEFAULT_TX (DEF)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .SCLK     (SCLK),
      .CS       (CS),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .txData   (txData),
      .txLoad   (txLoad),
      .rxData   (rxData),
      .rxValid  (rxValid),
      .busy     (busy),
      .txPending(txPending)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   // Monitor: every rxValid strobe must match the oldest outstanding byte.
   always @(negedge clk) begin
      if (reset && rxValid) begin
         checks++;
         if (rx_exp.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected actual=%h required=no_strobe", rxData);
         end else begin
            mon_exp = rx_exp.pop_front();
            if (rxData !== mon_exp) begin
               errors++;
               $display("FAIL rx_byte actual=%h required=%h", rxData, mon_exp);
            end else begin
               $display("rx_byte %h", rxData);
            end
         end
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end else begin
         $display("%s %h", name, act);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_tx(input logic [7:0] d);
      txData = d;
      txLoad = 1'b1;
      @(negedge clk);
      txLoad = 1'b0;
      model_hold = d;
      model_pend = 1'b1;
   endtask

   task automatic model_consume(output logic [7:0] b);
      b = model_pend ? model_hold : DEF;
      model_pend = 1'b0;
   endtask

   task automatic xfer_bits(input logic [7:0] b, input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         MOSI = b[i];
         wait_clk(H);
         SCLK = 1'b1;
         wait_clk(H);
         miso_acc[i] = MISO;
         SCLK = 1'b0;
         wait_clk(H);
      end
   endtask

   // Sends every byte in mosi_q under one CS assertion; abort_bits > 0 cuts
   // the first byte short and releases CS.
   task automatic run_frame(input int abort_bits, input bit mid_load, input logic [7:0] mid_val);
      logic [7:0] exp_tx;
      logic [7:0] mb;
      int         nb;
      nb = mosi_q.size();
      CS = 1'b0;
      model_consume(exp_tx);
      wait_clk(H);
      check("busy_in_frame", {7'd0, busy}, 8'h01);
      check("pending_at_cs_fall", {7'd0, txPending}, {7'd0, model_pend});
      for (int k = 0; k < nb; k++) begin
         mb = mosi_q[k];
         if (abort_bits > 0) begin
            xfer_bits(mb, 0, abort_bits);
            break;
         end
         rx_exp.push_back(mb);
         model_last_rx = mb;
         if (mid_load && k == 0) begin
            xfer_bits(mb, 0, 4);
            load_tx(mid_val);
            xfer_bits(mb, 4, 8);
         end else begin
            xfer_bits(mb, 0, 8);
         end
         check("miso_byte", miso_acc, exp_tx);
         model_consume(exp_tx);
      end
      mosi_q.delete();
      CS = 1'b1;
      wait_clk(H + 4);
      check("busy_after_frame", {7'd0, busy}, 8'h00);
      check("miso_idle", {7'd0, MISO}, 8'h00);
      check("rx_outstanding", 8'(rx_exp.size()), 8'h00);
      check("rxdata_hold", rxData, model_last_rx);
      check("pending_after", {7'd0, txPending}, {7'd0, model_pend});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"}, {7'd0, MISO}, 8'h00);
      check({tag, "_rxdata"}, rxData, 8'h00);
      check({tag, "_rxvalid"}, {7'd0, rxValid}, 8'h00);
      check({tag, "_busy"}, {7'd0, busy}, 8'h00);
      check({tag, "_pending"}, {7'd0, txPending}, 8'h00);
   endtask

   initial begin
      logic [7:0] dummy;
      int         n;

      wait_clk(3);
      check_reset_outputs("reset");
      reset = 1'b1;
      wait_clk(4);

      // basic frame
      load_tx(8'hDA);
      check("pending_loaded", {7'd0, txPending}, 8'h01);
      mosi_q.push_back(8'h69);
      run_frame(0, 1'b0, 8'h00);

      // nothing loaded: default byte returned
      mosi_q.push_back(8'hA5);
      run_frame(0, 1'b0, 8'h00);

      // back-to-back bytes with a load during the first one
      load_tx(8'h77);
      mosi_q.push_back(8'h01);
      mosi_q.push_back(8'h80);
      run_frame(0, 1'b1, 8'h3C);

      // aborted frame then a full one
      mosi_q.push_back(8'hC3);
      run_frame(5, 1'b0, 8'h00);
      mosi_q.push_back(8'hFF);
      run_frame(0, 1'b0, 8'h00);

      // another slave selected: SCLK toggles with CS high
      for (int i = 0; i < 8; i++) begin
         MOSI = i[0];
         wait_clk(H);
         SCLK = 1'b1;
         wait_clk(H);
         check("unsel_miso", {7'd0, MISO}, 8'h00);
         check("unsel_busy", {7'd0, busy}, 8'h00);
         SCLK = 1'b0;
         wait_clk(H);
      end

      // reset asserted mid-frame
      load_tx(8'hE7);
      CS = 1'b0;
      model_consume(dummy);
      wait_clk(H);
      xfer_bits(8'h33, 0, 4);
      load_tx(8'h11);
      check("pending_before_reset", {7'd0, txPending}, 8'h01);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      CS = 1'b1;
      SCLK = 1'b0;
      model_pend = 1'b0;
      model_last_rx = 8'h00;
      wait_clk(3);
      check_reset_outputs("heldreset");
      reset = 1'b1;
      wait_clk(H);
      mosi_q.push_back(8'h5A);
      run_frame(0, 1'b0, 8'h00);

      // randomized frames
      for (int r = 0; r < 8; r++) begin
         if ($urandom_range(0, 1) == 1) begin
            load_tx(8'($urandom));
         end
         n = $urandom_range(1, 3);
         for (int k = 0; k < n; k++) begin
            mosi_q.push_back(8'($urandom));
         end
         run_frame(0, 1'b0, 8'h00);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave endpoint that sits directly downstream of the SPI master, on one of its chip-select lines. It receives MOSI bits and returns a preloaded byte on MISO, both LSB first. It oversamples SCLK, CS and MOSI in the system clock domain, so the master and every slave run from one clock. Each received byte is handed to local logic as a single-cycle strobe.

## Interface

- DATA_WIDTH, 8: bits per frame.
- SYNC_STAGES, 2: flip-flop depth of the SCLK/CS/MOSI synchronizers (minimum 2).
- DEFAULT_TX, 8'h00: byte shifted out when no byte is pending.

- clk  in  1  system clock, rising edge; also clocks the SPI master.
- reset  in  1  asynchronous, active-low reset.
- SCLK  in  1  serial clock from the master; idles low.
- CS  in  1  this slave's chip select from the master's CS bus; active-low.
- MOSI  in  1  serial data from the master.
- MISO  out  1  serial data to the master.
- txData  in  DATA_WIDTH  byte to return in the next frame.
- txLoad  in  1  one-cycle strobe that writes txData into the holding register.
- rxData  out  DATA_WIDTH  last complete received byte.
- rxValid  out  1  one-cycle strobe: rxData was updated this cycle.
- busy  out  1  high while a frame is in progress.
- txPending  out  1  holding register loaded and not yet consumed.

## Operation

- Synchronize SCLK, CS and MOSI through SYNC_STAGES flops each. Keep one extra registered copy of SCLK and of CS for edge detection.
- Bit order is LSB first in both directions.
- Sample MOSI on each falling SCLK edge: rxShift <= {MOSI_s, rxShift[DATA_WIDTH-1:1]}.
- Update MISO on each rising SCLK edge: MISO <= txShift[0], then shift txShift right by 1.
- FSM IDLE:
  - MISO = 0, busy = 0.
  - On the CS falling edge: copy the holding register into txShift, or DEFAULT_TX if txPending = 0. Clear txPending, clear bitCnt, go to SHIFT.
- FSM SHIFT:
  - busy = 1. bitCnt counts falling SCLK edges, 0..DATA_WIDTH-1.
  - On the falling edge where bitCnt = DATA_WIDTH-1:
    - Go to DONE.
    - Wrap bitCnt to 0.
    - Reload txShift from the holding register (or DEFAULT_TX) and clear txPending. This allows back-to-back bytes while CS stays low.
- FSM DONE:
  - Lasts one clk: rxData <= rxShift, rxValid = 1.
  - Return to SHIFT if CS is still low, else IDLE.
- CS rising edge in SHIFT (frame aborted): go to IDLE. rxData is unchanged, no rxValid, bitCnt = 0, partial rxShift discarded, MISO returns to 0.
- txLoad at any time writes txData into the holding register and sets txPending. A load in the same cycle as a consume wins: txPending stays 1 with the new data.
- rxValid fires regardless of whether local logic read the previous byte. There is no overrun flag; rxData is simply overwritten.
- Edges of SCLK seen while CS is high are ignored.

## Timing

- Reset values:
  - MISO = 0, rxData = 0, rxValid = 0, busy = 0, txPending = 0.
  - txShift = DEFAULT_TX, rxShift = 0, bitCnt = 0, FSM = IDLE.
  - All synchronizer flops = 0, except the CS flops, which reset to 1.
- SPI pin to detected edge: SYNC_STAGES + 1 clk cycles.
- MISO changes SYNC_STAGES + 2 clk after the SCLK rise. This must settle before the next falling edge, at which the master samples.
- SCLK high time and low time must each be at least SYNC_STAGES + 3 clk. The master's divider guarantees this.
- rxValid pulses exactly 1 clk, SYNC_STAGES + 2 clk after the DATA_WIDTH-th SCLK fall.
- busy rises the clk after the CS-fall detection. It falls the clk after the CS-rise detection.
- Reset asserted mid-frame: all state returns to reset values immediately. The next frame starts only on a fresh CS falling edge.

## Test plan

- Basic frame: load txData = 8'hDA, master sends 8'h69 on CS[0] -> rxData = 8'h69 with one rxValid, master receives 8'hDA, txPending falls at the CS fall.
- No load: master sends 8'hA5 with txPending = 0 -> MISO returns DEFAULT_TX (8'h00), rxData = 8'hA5.
- Back-to-back: CS held low for 16 SCLK, bytes 8'h01 then 8'h80, second txData 8'h3C loaded mid-frame -> two rxValid pulses with 8'h01 then 8'h80, master receives DATA then 8'h3C.
- Abort: CS rises after 5 SCLK -> no rxValid, rxData unchanged, busy falls. The next full frame of 8'hFF is received correctly.
- Other slave selected: CS stays high while SCLK toggles -> MISO = 0, busy = 0, no rxValid.
- Async reset: assert reset after 4 bits, release, then a full frame of 8'h5A -> outputs show reset values while reset is low, then rxData = 8'h5A.
